// File: rtl/xosera_bus_sequencer_pkg.sv
// Shared types and default bus timing for the Xosera host-bus sequencer.
package xosera_bus_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } bus_seq_state_t;

    localparam int BUS_SETUP_CYC  = 1;
    localparam int BUS_STROBE_CYC = 4;
    localparam int BUS_GAP_CYC    = 4;
    localparam int BUS_SAMPLE_CYC = 2;

    typedef struct packed {
        logic        rd;
        logic [3:0]  reg_num;
        logic [15:0] data;
    } bus_req_t;

endpackage

// File: rtl/xosera_bus_sequencer.sv
// Host-bus master: turns one 16-bit register access into two 68k-style byte
// cycles (high byte then low byte) with fixed setup/strobe/gap timing.
module xosera_bus_sequencer
    import xosera_bus_sequencer_pkg::*;
#(
    parameter int SETUP_CYC  = BUS_SETUP_CYC,
    parameter int STROBE_CYC = BUS_STROBE_CYC,
    parameter int GAP_CYC    = BUS_GAP_CYC,
    parameter int SAMPLE_CYC = BUS_SAMPLE_CYC
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rd_i,
    input  logic [3:0]  req_reg_i,
    input  logic [15:0] req_data_i,
    output logic        resp_valid_o,
    output logic [15:0] resp_data_o,
    output logic        busy_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic        bus_bytesel_o,
    output logic [3:0]  bus_reg_num_o,
    output logic [7:0]  bus_data_o,
    input  logic [7:0]  bus_data_i
);

    localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CYC = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Each phase counts down from its length minus one and ends at zero.
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_CNT  = CNT_W'(STROBE_CYC - 1 - SAMPLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    if (SETUP_CYC < 1 || STROBE_CYC < 1 || GAP_CYC < 1 ||
        SAMPLE_CYC < 0 || SAMPLE_CYC >= STROBE_CYC) begin : g_param_check
        $error("xosera_bus_sequencer: illegal timing parameters");
    end

    bus_seq_state_t   state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             byte_idx, byte_idx_next;
    bus_req_t         req_q;
    logic [15:0]      shadow;
    logic             resp_valid_q;
    logic [15:0]      resp_data_q;
    logic             accept;
    logic             sample;
    logic             done;

    // Next-state logic: phase sequencing, byte stepping and read sampling.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        byte_idx_next = byte_idx;
        accept        = 1'b0;
        sample        = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    accept        = 1'b1;
                    state_next    = SETUP;
                    cnt_next      = SETUP_LOAD;
                    byte_idx_next = 1'b0;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_next = STROBE;
                    cnt_next   = STROBE_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            STROBE: begin
                sample = req_q.rd && (cnt == SAMPLE_CNT);
                if (cnt == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (!byte_idx) begin
                        byte_idx_next = 1'b1;
                        state_next    = SETUP;
                        cnt_next      = SETUP_LOAD;
                    end else begin
                        state_next = IDLE;
                        done       = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, request latch, read shadow and completion pulse registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state        <= IDLE;
            cnt          <= '0;
            byte_idx     <= 1'b0;
            req_q        <= '0;
            shadow       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            byte_idx     <= byte_idx_next;
            resp_valid_q <= done;
            resp_data_q  <= (done && req_q.rd) ? shadow : 16'h0000;
            if (accept) begin
                req_q <= '{rd: req_rd_i, reg_num: req_reg_i, data: req_data_i};
            end
            if (sample) begin
                if (byte_idx) begin
                    shadow[7:0] <= bus_data_i;
                end else begin
                    shadow[15:8] <= bus_data_i;
                end
            end
        end
    end

    assign req_ready_o   = (state == IDLE);
    assign busy_o        = (state != IDLE);
    assign resp_valid_o  = resp_valid_q;
    assign resp_data_o   = resp_data_q;
    assign bus_cs_n_o    = (state != STROBE);
    assign bus_rd_nwr_o  = (state == IDLE) ? 1'b1 : req_q.rd;
    assign bus_bytesel_o = (state == IDLE) ? 1'b0 : byte_idx;
    assign bus_reg_num_o = (state == IDLE) ? 4'h0 : req_q.reg_num;
    assign bus_data_o    = (state == IDLE || req_q.rd) ? 8'h00 :
                           (byte_idx ? req_q.data[7:0] : req_q.data[15:8]);

endmodule

// File: tb/tb_xosera_bus_sequencer.sv
// Self-checking bench: default-timing sequencer (dut0) and a 1/1/1/0 variant
// (dut1), both compared every cycle against a timeline model of a transaction.
module tb_xosera_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req_valid [2];
    logic        req_rd    [2];
    logic [3:0]  req_reg   [2];
    logic [15:0] req_data  [2];
    logic [7:0]  bus_din   [2];
    logic        req_ready [2];
    logic        resp_valid[2];
    logic [15:0] resp_data [2];
    logic        busy      [2];
    logic        cs_n      [2];
    logic        rd_nwr    [2];
    logic        bytesel   [2];
    logic [3:0]  reg_num   [2];
    logic [7:0]  bus_dout  [2];

    int cfg_s  [2] = '{1, 1};
    int cfg_t  [2] = '{4, 1};
    int cfg_g  [2] = '{4, 1};
    int cfg_smp[2] = '{2, 0};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Bytes the bus model returns for the next accepted read on each DUT.
    logic [7:0] rd_hi[2];
    logic [7:0] rd_lo[2];

    // Model state per DUT: the transaction in flight and when it was accepted.
    bit          m_armed;
    bit          m_act [2];
    int          m_acc [2];
    bit          m_rd  [2];
    logic [3:0]  m_reg [2];
    logic [15:0] m_data[2];
    logic [7:0]  m_hi  [2];
    logic [7:0]  m_lo  [2];

    // Observations of dut0's strobe windows and of completions on both DUTs.
    int         win_len  [$];
    int         win_gap  [$];
    logic [7:0] win_data [$];
    bit         win_sel  [$];
    bit         win_rdnwr[$];
    int         cur_low;
    int         cur_high;
    int         resp_cyc[2];
    logic [15:0] resp_val[2];

    xosera_bus_sequencer dut0 (
        .clk(clk), .reset_i(reset_i),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_rd_i(req_rd[0]), .req_reg_i(req_reg[0]), .req_data_i(req_data[0]),
        .resp_valid_o(resp_valid[0]), .resp_data_o(resp_data[0]), .busy_o(busy[0]),
        .bus_cs_n_o(cs_n[0]), .bus_rd_nwr_o(rd_nwr[0]), .bus_bytesel_o(bytesel[0]),
        .bus_reg_num_o(reg_num[0]), .bus_data_o(bus_dout[0]), .bus_data_i(bus_din[0])
    );

    xosera_bus_sequencer #(
        .SETUP_CYC(1), .STROBE_CYC(1), .GAP_CYC(1), .SAMPLE_CYC(0)
    ) dut1 (
        .clk(clk), .reset_i(reset_i),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_rd_i(req_rd[1]), .req_reg_i(req_reg[1]), .req_data_i(req_data[1]),
        .resp_valid_o(resp_valid[1]), .resp_data_o(resp_data[1]), .busy_o(busy[1]),
        .bus_cs_n_o(cs_n[1]), .bus_rd_nwr_o(rd_nwr[1]), .bus_bytesel_o(bytesel[1]),
        .bus_reg_num_o(reg_num[1]), .bus_data_o(bus_dout[1]), .bus_data_i(bus_din[1])
    );

    always #5 clk = ~clk;

    // Edge counter: value equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int d,
                               input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h",
                     name, d, cyc, act, exp);
        end
    endtask

    // Model, bus responder and per-cycle compare, evaluated mid-cycle.
    initial begin
        int P, k, b, r, S, T;
        logic e_ready, e_busy, e_csn, e_rdnwr, e_sel, e_rv;
        logic [3:0]  e_reg;
        logic [7:0]  e_dout, byte_v;
        logic [15:0] e_rdata;
        m_armed  = 0;
        m_act    = '{0, 0};
        m_acc    = '{0, 0};
        cur_low  = 0;
        cur_high = 0;
        resp_cyc = '{-1, -1};
        resp_val = '{16'h0, 16'h0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                S = cfg_s[d];
                T = cfg_t[d];
                P = S + T + cfg_g[d];
                k = cyc - m_acc[d] + 1;
                e_ready = 1; e_busy = 0; e_csn = 1; e_rdnwr = 1; e_sel = 0;
                e_reg = 4'h0; e_dout = 8'h00; e_rv = 0; e_rdata = 16'h0;
                b = 0; r = 0;
                if (m_act[d] && k >= 1 && k <= 2 * P) begin
                    b = (k - 1) / P;
                    r = (k - 1) % P;
                    e_ready = 0;
                    e_busy  = 1;
                    e_csn   = !(r >= S && r < S + T);
                    e_rdnwr = m_rd[d];
                    e_sel   = (b == 1);
                    e_reg   = m_reg[d];
                    e_dout  = m_rd[d] ? 8'h00 : ((b == 1) ? m_data[d][7:0] : m_data[d][15:8]);
                end else if (m_act[d] && k == 2 * P + 1) begin
                    e_rv    = 1;
                    e_rdata = m_rd[d] ? {m_hi[d], m_lo[d]} : 16'h0000;
                end
                if (m_armed) begin
                    checkOutput("req_ready",  d, req_ready[d],  e_ready);
                    checkOutput("busy",       d, busy[d],       e_busy);
                    checkOutput("cs_n",       d, cs_n[d],       e_csn);
                    checkOutput("rd_nwr",     d, rd_nwr[d],     e_rdnwr);
                    checkOutput("bytesel",    d, bytesel[d],    e_sel);
                    checkOutput("reg_num",    d, reg_num[d],    e_reg);
                    checkOutput("bus_data",   d, bus_dout[d],   e_dout);
                    checkOutput("resp_valid", d, resp_valid[d], e_rv);
                    checkOutput("resp_data",  d, resp_data[d],  e_rdata);
                    if (resp_valid[d] === 1'b1) begin
                        resp_cyc[d] = cyc + 1;
                        resp_val[d] = resp_data[d];
                    end
                    if (d == 0) begin
                        if (cs_n[0] === 1'b0) begin
                            if (cur_low == 0) begin
                                win_data.push_back(bus_dout[0]);
                                win_sel.push_back(bytesel[0]);
                                win_rdnwr.push_back(rd_nwr[0]);
                                win_gap.push_back(cur_high);
                            end
                            cur_low++;
                            cur_high = 0;
                        end else begin
                            if (cur_low > 0) win_len.push_back(cur_low);
                            cur_low = 0;
                            cur_high++;
                        end
                    end
                end
                // Read data is only correct at the sample slot of each strobe.
                bus_din[d] = 8'($urandom);
                if (m_act[d] && m_rd[d] && k >= 1 && k <= 2 * P && r >= S && r < S + T) begin
                    byte_v = (b == 1) ? m_lo[d] : m_hi[d];
                    bus_din[d] = (r - S == cfg_smp[d]) ? byte_v : ~byte_v;
                end
                if (reset_i) begin
                    m_act[d] = 0;
                end else if (m_armed && e_ready && req_valid[d]) begin
                    m_act[d]  = 1;
                    m_acc[d]  = cyc + 1;
                    m_rd[d]   = req_rd[d];
                    m_reg[d]  = req_reg[d];
                    m_data[d] = req_data[d];
                    m_hi[d]   = rd_hi[d];
                    m_lo[d]   = rd_lo[d];
                end else if (m_act[d] && k >= 2 * P + 1) begin
                    m_act[d] = 0;
                end
            end
            if (reset_i) m_armed = 1;
        end
    end

    // Present a request and hold it until the DUT takes it; returns the edge.
    task automatic applyStimulus(input int d, input bit rd, input logic [3:0] rg,
                                 input logic [15:0] dat, input logic [7:0] hi,
                                 input logic [7:0] lo, input bit hold, output int acc);
        bit rdy;
        rd_hi[d]     = hi;
        rd_lo[d]     = lo;
        req_rd[d]    = rd;
        req_reg[d]   = rg;
        req_data[d]  = dat;
        req_valid[d] = 1'b1;
        acc = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            @(negedge clk);
            rdy = req_ready[d];
            @(posedge clk);
            #2;
            if (rdy) acc = cyc;
        end
        if (acc < 0) checkOutput("accept_timeout", d, 0, 1);
        if (!hold) begin
            req_valid[d] = 1'b0;
            req_data[d]  = 16'($urandom);
            req_reg[d]   = 4'($urandom);
            req_rd[d]    = 1'($urandom);
        end
    endtask

    // Wait for a completion sampled after edge 'after'; bounded.
    task automatic waitResp(input int d, input int after, output int at, output logic [15:0] val);
        at = -1;
        val = 16'h0;
        for (int i = 0; i < 100 && at < 0; i++) begin
            @(posedge clk);
            #2;
            if (resp_cyc[d] > after) begin
                at  = resp_cyc[d];
                val = resp_val[d];
            end
        end
        if (at < 0) checkOutput("resp_timeout", d, 0, 1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clearWindows();
        win_len.delete();
        win_gap.delete();
        win_data.delete();
        win_sel.delete();
        win_rdnwr.delete();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc, acc2, at, dd;
        logic [15:0] val;
        reset_i = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 0; req_rd[d] = 0; req_reg[d] = 0; req_data[d] = 0;
            bus_din[d] = 0; rd_hi[d] = 0; rd_lo[d] = 0;
        end
        idleCycles(3);
        reset_i = 1'b0;
        idleCycles(2);

        $display("[TB] write reg 5 <- 0x1234");
        clearWindows();
        applyStimulus(0, 0, 4'd5, 16'h1234, 8'h00, 8'h00, 0, acc);
        waitResp(0, acc, at, val);
        checkOutput("wr_latency", 0, at - acc, 19);
        checkOutput("wr_resp_data", 0, val, 16'h0000);
        checkOutput("wr_windows", 0, win_len.size(), 2);
        if (win_len.size() == 2 && win_data.size() == 2) begin
            checkOutput("wr_win0_len", 0, win_len[0], 4);
            checkOutput("wr_win1_len", 0, win_len[1], 4);
            checkOutput("wr_win_gap", 0, win_gap[1], 5);
            checkOutput("wr_win0_data", 0, win_data[0], 8'h12);
            checkOutput("wr_win0_sel", 0, win_sel[0], 0);
            checkOutput("wr_win0_rdnwr", 0, win_rdnwr[0], 0);
            checkOutput("wr_win1_data", 0, win_data[1], 8'h34);
            checkOutput("wr_win1_sel", 0, win_sel[1], 1);
        end

        $display("[TB] read reg 6, bus returns AB/CD");
        applyStimulus(0, 1, 4'd6, 16'hFFFF, 8'hAB, 8'hCD, 0, acc);
        waitResp(0, acc, at, val);
        checkOutput("rd_latency", 0, at - acc, 19);
        checkOutput("rd_resp_data", 0, val, 16'hABCD);

        $display("[TB] back-to-back writes");
        idleCycles(2);
        clearWindows();
        applyStimulus(0, 0, 4'd0, 16'h0010, 8'h00, 8'h00, 1, acc);
        applyStimulus(0, 0, 4'd1, 16'h8000, 8'h00, 8'h00, 0, acc2);
        checkOutput("b2b_accept_gap", 0, acc2 - acc, 19);
        waitResp(0, acc2, at, val);
        checkOutput("b2b_latency", 0, at - acc2, 19);
        checkOutput("b2b_windows", 0, win_len.size(), 4);
        if (win_data.size() == 4) begin
            checkOutput("b2b_idle_gap", 0, win_gap[2], 6);
            checkOutput("b2b_win2_data", 0, win_data[2], 8'h80);
            checkOutput("b2b_win3_data", 0, win_data[3], 8'h00);
        end

        $display("[TB] reset during second strobe of a read");
        applyStimulus(0, 1, 4'd6, 16'h0000, 8'h11, 8'h22, 0, acc);
        while (cyc < acc + 11) idleCycles(1);
        reset_i = 1'b1;
        idleCycles(1);
        reset_i = 1'b0;
        checkOutput("rst_cs_n", 0, cs_n[0], 1);
        checkOutput("rst_busy", 0, busy[0], 0);
        checkOutput("rst_ready", 0, req_ready[0], 1);
        idleCycles(25);
        checkOutput("rst_no_resp", 0, resp_cyc[0] > acc, 0);
        applyStimulus(0, 0, 4'd9, 16'hBEEF, 8'h00, 8'h00, 0, acc);
        waitResp(0, acc, at, val);
        checkOutput("post_rst_latency", 0, at - acc, 19);

        $display("[TB] fast variant read 0x5AA5");
        applyStimulus(1, 1, 4'd3, 16'h0000, 8'h5A, 8'hA5, 0, acc);
        waitResp(1, acc, at, val);
        checkOutput("fast_latency", 1, at - acc, 7);
        checkOutput("fast_resp_data", 1, val, 16'h5AA5);

        $display("[TB] request pulsed while busy");
        clearWindows();
        applyStimulus(0, 0, 4'd2, 16'hC3A5, 8'h00, 8'h00, 0, acc);
        while (cyc < acc + 4) idleCycles(1);
        req_rd[0] = 1'b1; req_reg[0] = 4'hF; req_data[0] = 16'hFFFF; req_valid[0] = 1'b1;
        idleCycles(1);
        req_valid[0] = 1'b0;
        waitResp(0, acc, at, val);
        checkOutput("busy_pulse_latency", 0, at - acc, 19);
        if (win_data.size() == 2) begin
            checkOutput("busy_pulse_hi", 0, win_data[0], 8'hC3);
            checkOutput("busy_pulse_lo", 0, win_data[1], 8'hA5);
        end
        checkOutput("busy_pulse_windows", 0, win_data.size(), 2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 24; i++) begin
            dd = int'($urandom_range(0, 1));
            applyStimulus(dd, 1'($urandom), 4'($urandom), 16'($urandom),
                          8'($urandom), 8'($urandom), 0, acc);
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(dd, 1'($urandom), 4'($urandom), 16'($urandom),
                              8'($urandom), 8'($urandom), 0, acc);
            end
            waitResp(dd, acc, at, val);
            idleCycles(int'($urandom_range(0, 3)));
        end

        idleCycles(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
